// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot loader that receives a program over a UART line and writes it into
// the instruction memory of a pipeline core, holding the core in reset
// until the whole image has landed.
//
// Frame format (bytes, each sent 8N1, LSB first):
//   4 header bytes : word count N, little-endian (1..WORDS accepted)
//   4*N data bytes : N little-endian 32-bit words, written to imem[0..N-1]
//   1 checksum byte: XOR of all 4*N data bytes (only with the macro below)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   -> a trailing checksum byte is required; mismatch enters ERR
//   undefined -> DONE follows the last imem write directly
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (>= 4)
//   WORDS        : instruction-memory depth in 32-bit words
//   AW           : imem word-address width (2**AW >= WORDS)
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   rxd        : asynchronous UART receive line, idle high
//   imem_addr  : registered imem word address
//   imem_wdata : registered imem write data
//   imem_we    : registered one-cycle imem write strobe
//   core_rst   : reset for the core, low only once the load succeeded
//   busy       : frame in progress (first header byte seen, not DONE/ERR)
//   done       : load completed successfully
//   err        : sticky error (framing, bad word count, bad checksum)
//   dbg_state  : {rx_state[1:0], ld_state[2:0]} for checkers and debug
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 4096,
    parameter int AW           = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          imem_we,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [4:0]    dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    // -----------------------------------------------------------------------
    // Input synchronizer. rx_s3 is only the previous value of rx_s2, used
    // for falling-edge detection; all sampling uses rx_s2.
    // -----------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // -----------------------------------------------------------------------
    // UART receiver FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit_idx;
    logic [7:0]      rx_shift;
    logic            rx_tick;
    logic            rx_fall;
    logic            rx_bit_shift;
    logic            rx_byte_ok;
    logic            rx_byte_bad;

    // Handshake between receiver and loader: rx_valid is a one-cycle strobe
    // qualifying rx_byte; there is no ready, the loader always consumes the
    // byte in the strobe cycle. frame_err is a one-cycle strobe for a stop
    // bit sampled low (rx_valid stays low for that byte).
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            frame_err;

    assign rx_fall = rx_s3 & ~rx_s2;
    // Start bit is checked half a bit after the edge; every later sample is
    // a full bit apart, which lands each one at mid-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_M1) : (rx_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    // Line back high at mid-start: treat as glitch.
                    rx_next = rx_s2 ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (rx_tick && (rx_bit_idx == 3'd7)) begin
                    rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_bit_shift = 1'b0;
        rx_byte_ok   = 1'b0;
        rx_byte_bad  = 1'b0;
        case (rx_state)
            RX_BITS: rx_bit_shift = rx_tick;
            RX_STOP: begin
                rx_byte_ok  = rx_tick & rx_s2;
                rx_byte_bad = rx_tick & ~rx_s2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= rx_byte_ok;
            frame_err <= rx_byte_bad;
            if (rx_tick || (rx_state == RX_IDLE)) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (rx_state == RX_IDLE) begin
                rx_bit_idx <= '0;
            end else if (rx_bit_shift) begin
                rx_bit_idx <= rx_bit_idx + 3'd1;
            end
            if (rx_bit_shift) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end
        end
    end

    // The shift register is stable from the stop sample until the next
    // start bit's first data sample, so it can be presented directly.
    assign rx_byte = rx_shift;

    // -----------------------------------------------------------------------
    // Loader FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } ld_state_t;

    ld_state_t   state, next_state;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_w;
    logic [31:0] assembled;
    logic [AW:0] n_words;
    logic [AW:0] word_idx;
    logic        accept;
    logic        last_write;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Current byte completes a little-endian word with the three before it.
    assign assembled = {rx_byte, shift_w};
    assign accept    = rx_valid && ((state == ST_HDR) || (state == ST_DATA));
    // word_idx is bumped together with the write strobe, so during the
    // write cycle it already equals the number of words written.
    assign last_write = imem_we && (word_idx == n_words);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_HDR: begin
                if (frame_err) begin
                    next_state = ST_ERR;
                end else if (rx_valid && (byte_cnt == 2'd3)) begin
                    if ((assembled == 32'd0) || (assembled > 32'(WORDS))) begin
                        next_state = ST_ERR;
                    end else begin
                        next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (frame_err) begin
                    next_state = ST_ERR;
                end else if (last_write) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    next_state = ST_CSUM;
`else
                    next_state = ST_DONE;
`endif
                end
            end
            ST_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (frame_err) begin
                    next_state = ST_ERR;
                end else if (rx_valid) begin
                    next_state = (rx_byte == csum) ? ST_DONE : ST_ERR;
                end
`else
                next_state = ST_ERR;
`endif
            end
            ST_DONE: next_state = ST_DONE;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_ERR;
        endcase
    end

    always_comb begin
        core_rst = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_HDR:  busy = (byte_cnt != 2'd0);
            ST_DATA: busy = 1'b1;
            ST_CSUM: busy = 1'b1;
            ST_DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte assembly, word count, write port, running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            shift_w    <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_w  <= {rx_byte, shift_w[23:8]};
                if (byte_cnt == 2'd3) begin
                    if (state == ST_HDR) begin
                        // Only meaningful once validated against WORDS.
                        n_words <= assembled[AW:0];
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[AW-1:0];
                        imem_wdata <= assembled;
                        word_idx   <= word_idx + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (accept && (state == ST_DATA)) begin
            csum <= csum ^ rx_byte;
        end
    end
`endif

    assign dbg_state = {rx_state, state};

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed and randomized frames for prog_loader (CLKS_PER_BIT=4, WORDS=16,
// AW=4). Expected imem writes and final status come from a frame-level model
// that parses the transmitted byte list; a monitor collects the real writes.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int CPB   = 4;
    localparam int WORDS = 16;
    localparam int AW    = 4;
    localparam int W     = AW + 32;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    logic rxd;
    always #5 clk = ~clk;

    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_we;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [4:0]    dbg_state;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .WORDS       (WORDS),
        .AW          (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .imem_we   (imem_we),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   tx_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic         exp_done;
    logic         exp_err;
    logic         we_prev = 1'b0;

    // Write monitor: every strobe must be exactly one cycle long.
    always @(negedge clk) begin
        if (imem_we) begin
            checks++;
            assert (we_prev === 1'b0) else begin
                errors++;
                $error("FAIL we_pulse_width: observed strobe high %0d cycles in a row, expected 1", 2);
            end
            obs_q.push_back({imem_addr, imem_wdata});
        end
        we_prev = imem_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        send_bit(1'b1);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'(w >> (8 * i)));
    endtask

    task automatic add_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 4; i < tx_q.size(); i++) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
    endtask

    // Frame-level reference: parse tx_q as the receiver would see it, with
    // byte index 'bad' (if >= 0) arriving with a broken stop bit.
    task automatic model(input int bad);
        logic [31:0] n;
        logic [31:0] w;
        logic [7:0]  x;
        int          base;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (bad >= 0 && bad < 4) begin
            exp_err = 1'b1;
            return;
        end
        n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
        if (n == 0 || n > WORDS) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
            base = 4 + 4 * i;
            if (bad >= 0 && bad < base + 4) begin
                exp_err = 1'b1;
                return;
            end
            w = {tx_q[base + 3], tx_q[base + 2], tx_q[base + 1], tx_q[base]};
            x = x ^ tx_q[base] ^ tx_q[base + 1] ^ tx_q[base + 2] ^ tx_q[base + 3];
            exp_q.push_back({AW'(i), w});
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (bad == 4 + 4 * int'(n) || tx_q[4 + 4 * int'(n)] != x) exp_err = 1'b1;
        else exp_done = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    // Scoreboard: send tx_q, then compare writes and final status.
    task automatic run_frame(input int bad, input bit probe);
        logic [W-1:0] v;
        model(bad);
        obs_q.delete();
        for (int k = 0; k < tx_q.size(); k++) begin
            send_byte(tx_q[k], k != bad);
            if (probe && k == 0) begin
                check("busy_after_byte0", 64'(busy), 64'd1);
                check("core_rst_mid_frame", 64'(core_rst), 64'd1);
                check("done_mid_frame", 64'(done), 64'd0);
            end
        end
        for (int t = 0; t < 300 && !(done || err); t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            v = (i < obs_q.size()) ? obs_q[i] : 'x;
            check($sformatf("write[%0d]", i), 64'(v), 64'(exp_q[i]));
        end
        check("done", 64'(done), 64'(exp_done));
        check("err", 64'(err), 64'(exp_err));
        check("core_rst", 64'(core_rst), 64'(!exp_done));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        int          mode;
        int          nw;
        logic [31:0] n;

        rst = 1'b1;
        rxd = 1'b1;
        do_reset();
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // Single word, with mid-frame probe
        tx_q.delete();
        push_word(32'd1);
        push_word(32'h12345678);
        add_csum();
        run_frame(-1, 1'b1);

        // Traffic after DONE is ignored
        obs_q.delete();
        tx_q.delete();
        push_word(32'd1);
        push_word(32'hCAFEF00D);
        for (int k = 0; k < tx_q.size(); k++) send_byte(tx_q[k], 1'b1);
        repeat (10) @(negedge clk);
        check("done_ignores_rx_writes", 64'(obs_q.size()), 64'd0);
        check("done_holds", 64'(done), 64'd1);

        // Start-bit glitch, then three words
        do_reset();
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy", 64'(busy), 64'd0);
        tx_q.delete();
        push_word(32'd3);
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'hDEADBEEF);
        add_csum();
        run_frame(-1, 1'b0);

        // Word count zero and word count above depth
        do_reset();
        tx_q.delete();
        push_word(32'd0);
        push_word(32'h11223344);
        run_frame(-1, 1'b0);

        do_reset();
        tx_q.delete();
        push_word(32'd17);
        push_word(32'h55667788);
        run_frame(-1, 1'b0);

        // Full-depth image
        do_reset();
        tx_q.delete();
        push_word(WORDS);
        for (int i = 0; i < WORDS; i++) push_word($urandom);
        add_csum();
        run_frame(-1, 1'b0);

        // Framing error in the second data word
        do_reset();
        tx_q.delete();
        push_word(32'd2);
        push_word(32'hA5A5A5A5);
        push_word(32'h5A5A5A5A);
        add_csum();
        run_frame(9, 1'b0);

        // Reset in the middle of word 1, then a fresh frame
        do_reset();
        tx_q.delete();
        push_word(32'd2);
        push_word(32'h01010101);
        push_word(32'h02020202);
        for (int k = 0; k < 10; k++) send_byte(tx_q[k], 1'b1);
        check("busy_mid_word", 64'(busy), 64'd1);
        do_reset();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_core_rst", 64'(core_rst), 64'd1);
        check("rst_mid_done", 64'(done), 64'd0);
        tx_q.delete();
        push_word(32'd2);
        push_word(32'hBBBB0000);
        push_word(32'hCCCC1111);
        add_csum();
        run_frame(-1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        tx_q.delete();
        push_word(32'd1);
        push_word(32'h01020304);
        tx_q.push_back(8'h05);
        run_frame(-1, 1'b0);

        do_reset();
        tx_q.delete();
        push_word(32'd1);
        push_word(32'h01020304);
        tx_q.push_back(8'h04);
        run_frame(-1, 1'b0);
`endif

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            do_reset();
            tx_q.delete();
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom_range(17, 32'h0000FFFF);
                push_word(n);
                push_word($urandom);
                run_frame(-1, 1'b0);
            end else begin
                nw = $urandom_range(1, WORDS);
                push_word(32'(nw));
                for (int i = 0; i < nw; i++) push_word($urandom);
                add_csum();
                if (mode == 1) run_frame($urandom_range(0, tx_q.size() - 1), 1'b0);
                else run_frame(-1, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (>=4).
REQ-002 SHALL provide parameter WORDS, default 4096, instruction-memory depth in 32-bit words.
REQ-003 SHALL provide parameter AW, default 12, imem word-address width (2**AW >= WORDS).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rxd  input  1  asynchronous UART receive line, idle high.
REQ-007 imem_addr  output  AW  imem word address for write.
REQ-008 imem_wdata  output  32  imem write data.
REQ-009 imem_we  output  1  one-cycle imem write strobe.
REQ-010 core_rst  output  1  reset to the pipeline core; high until a program is fully loaded.
REQ-011 busy  output  1  high while a frame is in progress (header byte 0 received, not yet DONE/ERR).
REQ-012 done  output  1  high once the load completed successfully.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-015 RX SHALL detect start on a synchronized falling edge, resample at CLKS_PER_BIT/2; if high, discard as glitch and return to idle.
REQ-016 RX SHALL then sample 8 data bits LSB first and the stop bit, each CLKS_PER_BIT cycles apart at mid-bit.
REQ-017 A stop bit sampled low SHALL be a framing error: enter ERR.
REQ-018 Loader FSM states: HDR, DATA, CSUM (macro only), DONE, ERR.
REQ-019 HDR: first 4 bytes SHALL form word count N, little-endian.
REQ-020 N==0 or N>WORDS SHALL enter ERR after the 4th header byte; no imem write.
REQ-021 DATA: each 4 bytes SHALL form one little-endian word; imem_we pulses exactly one cycle, the cycle after the 4th byte is accepted, with imem_addr = word index (0..N-1).
REQ-022 Word index SHALL increment after each write; partial words are never written.
REQ-023 After write N-1, FSM SHALL go to CSUM (macro) or DONE the next cycle.
REQ-024 DONE: done=1, core_rst=0, busy=0; further rxd activity ignored; stays until rst.
REQ-025 ERR: err=1, core_rst=1, done=0, busy=0, imem_we=0; stays until rst.
REQ-026 core_rst SHALL be 1 in every state except DONE, deasserting the same cycle done rises.
REQ-027 imem_we, imem_addr, imem_wdata SHALL be registered outputs.

Reset
REQ-028 On rst: FSM=HDR, RX idle, word index=0, byte counter=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0.
REQ-029 rst mid-byte or mid-word SHALL discard the partial byte/word; loading restarts at header.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: after the last data word one checksum byte SHALL be received in CSUM; equals XOR of all 4*N payload bytes -> DONE, otherwise ERR.
REQ-031 Macro undefined: no CSUM state, no checksum byte; DONE follows last write directly.

Verification (CLKS_PER_BIT=4, WORDS=16, AW=4)
REQ-032 Send 01 00 00 00, 78 56 34 12 (+csum 08 if macro) -> one imem_we with addr 0, data 0x12345678; done=1, core_rst=0.
REQ-033 Send N=3 and words 0x00000001, 0x00000002, 0xDEADBEEF -> writes at addr 0,1,2 in order, one cycle each, then done.
REQ-034 Send header 00 00 00 00 -> err=1 after 4th byte, no imem_we, core_rst stays 1; header 11 00 00 00 (N=17) -> same.
REQ-035 Byte with stop bit driven low during DATA -> err=1 within one bit time of stop sample, no further writes.
REQ-036 Assert rst after 2 bytes of word 1, then resend full valid N=2 frame -> writes addr 0,1 only with new data; done=1.
REQ-037 Macro on: N=1 word 0x01020304 with checksum 0x05 -> err=1, core_rst=1; checksum 0x04 -> done=1.
